// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the neuron MAC output controller.
// Holds the enable levels, the default datapath width and the FSM state codes.
package mac_seq_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // The state codes are kept as plain constants so that older blocks can
  // share the same encoding.
  localparam logic [1:0] MAC_IDLE  = 2'd0;
  localparam logic [1:0] MAC_ACCUM = 2'd1;
  localparam logic [1:0] MAC_DONE  = 2'd2;

endpackage

// File: rtl/mac_sat_sel.sv
// Next-result selector for the MAC output stage.
// On the first overflow it picks the saturation bound for the overflow direction.
// Once the result has saturated, it keeps that value for the rest of the evaluation.
// This block is combinational, so the accumulator can reuse it.
module mac_sat_sel
  import mac_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_ac_out,
  input  logic                  i_ac_ovf,
  input  logic                  i_ac_ovf_neg,
  input  logic                  i_mac_sat,
  input  logic [DATA_WIDTH-1:0] i_mac_out,
  output logic [DATA_WIDTH-1:0] o_mac_out_nxt,
  output logic                  o_mac_sat_nxt
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // A saturated result is frozen; otherwise an overflow clamps, else pass through.
  always_comb begin
    o_mac_out_nxt = i_mac_out;
    o_mac_sat_nxt = i_mac_sat;
    if (i_mac_sat == DISABLE) begin
      if (i_ac_ovf == ENABLE) begin
        o_mac_out_nxt = i_ac_ovf_neg ? SAT_MIN : SAT_MAX;
        o_mac_sat_nxt = ENABLE;
      end else begin
        o_mac_out_nxt = i_ac_out;
      end
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Neuron MAC output controller.
// Counts accumulator-ready beats for a selectable number of taps.
// It tracks the running (possibly saturated) accumulator value.
// The final result goes to the activation stage under a ready/ack handshake.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  MAX_TAPS   = 8,
  localparam int CNT_W      = $clog2(MAX_TAPS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      tap_num,
  input  logic                  ac_rdy,
  input  logic [DATA_WIDTH-1:0] ac_out,
  input  logic                  ac_ovf,
  input  logic                  ac_ovf_neg,
  input  logic                  mac_ack,
  output logic [DATA_WIDTH-1:0] mac_out,
  output logic                  mac_rdy,
  output logic                  mac_sat,
  output logic                  busy,
  output logic [CNT_W-1:0]      tap_cnt
);

  localparam logic [CNT_W-1:0] TAP_MAX = CNT_W'(MAX_TAPS);
  localparam logic [CNT_W-1:0] TAP_ONE = CNT_W'(1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_tap_lim;
  logic [CNT_W-1:0]      r_tap_cnt;
  logic [DATA_WIDTH-1:0] r_mac_out;
  logic                  r_mac_rdy;
  logic                  r_mac_sat;
  logic                  r_busy;

  logic                  w_start_acc;
  logic [CNT_W-1:0]      w_tap_lim;
  logic                  w_beat;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_mac_out_nxt;
  logic                  w_mac_sat_nxt;

  // A start is taken when idle, or in DONE together with the consumer's ack.
  // The ack/start pairing gives back-to-back evaluations.
  assign w_start_acc = start && ((r_state == MAC_IDLE) ||
                                 ((r_state == MAC_DONE) && mac_ack));
  assign w_tap_lim   = (tap_num > TAP_MAX) ? TAP_MAX : tap_num;
  assign w_beat      = (r_state == MAC_ACCUM) && ac_rdy;
  assign w_last      = w_beat && (r_tap_cnt == (r_tap_lim - TAP_ONE));

  mac_sat_sel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sat_sel (
    .i_ac_out     (ac_out),
    .i_ac_ovf     (ac_ovf),
    .i_ac_ovf_neg (ac_ovf_neg),
    .i_mac_sat    (r_mac_sat),
    .i_mac_out    (r_mac_out),
    .o_mac_out_nxt(w_mac_out_nxt),
    .o_mac_sat_nxt(w_mac_sat_nxt)
  );

  // Control FSM: sequences IDLE -> ACCUM -> DONE and drives the busy/ready flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= MAC_IDLE;
      r_tap_lim <= '0;
      r_busy    <= DISABLE;
      r_mac_rdy <= DISABLE;
    end else begin
      case (r_state)
        MAC_IDLE, MAC_DONE: begin
          if (w_start_acc) begin
            r_tap_lim <= w_tap_lim;
            if (w_tap_lim == '0) begin
              r_state   <= MAC_DONE;
              r_busy    <= DISABLE;
              r_mac_rdy <= ENABLE;
            end else begin
              r_state   <= MAC_ACCUM;
              r_busy    <= ENABLE;
              r_mac_rdy <= DISABLE;
            end
          end else if ((r_state == MAC_DONE) && mac_ack) begin
            r_state   <= MAC_IDLE;
            r_mac_rdy <= DISABLE;
          end
        end
        MAC_ACCUM: begin
          if (w_last) begin
            r_state   <= MAC_DONE;
            r_busy    <= DISABLE;
            r_mac_rdy <= ENABLE;
          end
        end
        default: begin
          r_state   <= MAC_IDLE;
          r_busy    <= DISABLE;
          r_mac_rdy <= DISABLE;
        end
      endcase
    end
  end

  // Beat counter: cleared on an accepted start, counts accepted beats, never passes the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tap_cnt <= '0;
    end else if (w_start_acc) begin
      r_tap_cnt <= '0;
    end else if (w_beat && (r_tap_cnt != r_tap_lim)) begin
      r_tap_cnt <= r_tap_cnt + TAP_ONE;
    end
  end

  // Result datapath: cleared on start, updated on each beat through the saturation selector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mac_out <= '0;
      r_mac_sat <= DISABLE;
    end else if (w_start_acc) begin
      r_mac_out <= '0;
      r_mac_sat <= DISABLE;
    end else if (w_beat) begin
      r_mac_out <= w_mac_out_nxt;
      r_mac_sat <= w_mac_sat_nxt;
    end
  end

  assign mac_out = r_mac_out;
  assign mac_rdy = r_mac_rdy;
  assign mac_sat = r_mac_sat;
  assign busy    = r_busy;
  assign tap_cnt = r_tap_cnt;

endmodule
